// File: rtl/sr_deserializer.sv
// LSB-first serial-to-parallel receiver; word is valid the cycle after the last bit strobe.
// A finished word is dropped and ovr is set if the previous word was neither taken nor acknowledged.
module sr_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic                       start,
    input  logic                       sft,
    input  logic                       sin,
    input  logic                       dack,
    output logic [WIDTH-1:0]           dout,
    output logic                       dvalid,
    output logic                       busy,
    output logic [$clog2(WIDTH+1)-1:0] cnt,
    output logic                       ovr
);

    localparam int CW = $clog2(WIDTH+1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:1] r_sr;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dout;
    logic             r_dvalid;
    logic             r_busy;
    logic             r_ovr;

    logic [WIDTH-1:0] w_word;

    // Bit 0 of the shifter would fall off on the completing shift, so it is never stored.
    assign w_word = {sin, r_sr};

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state  <= IDLE;
            r_sr     <= '0;
            r_cnt    <= '0;
            r_dout   <= '0;
            r_dvalid <= 1'b0;
            r_busy   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            if (r_dvalid && dack) begin
                r_dvalid <= 1'b0;
            end
            if (start) begin
                r_state <= RECV;
                r_busy  <= 1'b1;
                r_sr    <= '0;
                r_cnt   <= '0;
                r_ovr   <= 1'b0;
            end else if (r_state == RECV && sft) begin
                if (r_cnt == LAST) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    r_sr    <= '0;
                    // An ack in the completion cycle frees the holding register for the new word.
                    if (!r_dvalid || dack) begin
                        r_dout   <= w_word;
                        r_dvalid <= 1'b1;
                    end else begin
                        r_ovr <= 1'b1;
                    end
                end else begin
                    r_sr  <= w_word[WIDTH-1:1];
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign dout   = r_dout;
    assign dvalid = r_dvalid;
    assign busy   = r_busy;
    assign cnt    = r_cnt;
    assign ovr    = r_ovr;

endmodule

// File: tb/tb_sr_deserializer.sv
// Directed bench for sr_deserializer (WIDTH=4) with a queue-based scoreboard on completed words.
module tb_sr_deserializer;

    logic       clk;
    logic       clr_n;
    logic       start;
    logic       sft;
    logic       sin;
    logic       dack;
    logic [3:0] dout;
    logic       dvalid;
    logic       busy;
    logic [2:0] cnt;
    logic       ovr;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_q[$];
    logic       prev_busy = 1'b0;

    sr_deserializer #(.WIDTH(4)) dut (
        .clk    (clk),
        .clr_n  (clr_n),
        .start  (start),
        .sft    (sft),
        .sin    (sin),
        .dack   (dack),
        .dout   (dout),
        .dvalid (dvalid),
        .busy   (busy),
        .cnt    (cnt),
        .ovr    (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a completion shows up as busy falling while dvalid is high.
    always @(negedge clk) begin
        if (prev_busy && !busy && dvalid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL word_unexpected: got %0h expected none", dout);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    bad++;
                    $display("FAIL word: got %0h expected %0h", dout, e);
                end
            end
        end
        prev_busy = busy;
    end

    // One clock cycle with the given inputs, then return 1 time unit after the edge.
    task automatic cyc(input logic st, input logic sf, input logic si, input logic ak);
        start = st;
        sft   = sf;
        sin   = si;
        dack  = ak;
        @(posedge clk);
        #1;
        start = 1'b0;
        sft   = 1'b0;
        sin   = 1'b0;
        dack  = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] w, input int gap, input logic ack_last,
                             input logic [3:0] exp_dout);
        exp_q.push_back(exp_dout);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b1, w[i], (i == 3) ? ack_last : 1'b0);
        end
    endtask

    initial begin
        clr_n = 1'b0;
        start = 1'b0;
        sft   = 1'b0;
        sin   = 1'b0;
        dack  = 1'b0;
        #2;
        check("rst_dout", dout, 0);
        check("rst_dvalid", dvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", cnt, 0);
        check("rst_ovr", ovr, 0);
        #10;
        clr_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame: bits 1,1,0,1 -> 4'b1011
        exp_q.push_back(4'hB);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("basic_busy_start", busy, 1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("basic_cnt3", cnt, 3);
        check("basic_busy_mid", busy, 1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        check("basic_dout", dout, 4'hB);
        check("basic_dvalid", dvalid, 1);
        check("basic_busy_done", busy, 0);
        check("basic_cnt_wrap", cnt, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("basic_ack", dvalid, 0);
        check("basic_dout_hold", dout, 4'hB);

        // Strobes in IDLE are ignored; gapped frame gives the same word
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("idle_sft_cnt", cnt, 0);
        check("idle_sft_busy", busy, 0);
        check("idle_sft_dvalid", dvalid, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("idle_ack_nop", dvalid, 0);
        send_word(4'hB, 3, 1'b0, 4'hB);
        check("gap_dout", dout, 4'hB);
        check("gap_dvalid", dvalid, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Restart mid-frame discards the partial word
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("restart_cnt2", cnt, 2);
        send_word(4'hC, 0, 1'b0, 4'hC);
        check("restart_dout", dout, 4'hC);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        check("start_sft_idle_cnt", cnt, 0);
        check("start_sft_idle_busy", busy, 1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        check("one_bit_cnt", cnt, 1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        check("start_sft_recv_cnt", cnt, 0);
        send_word(4'h6, 1, 1'b0, 4'h6);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Overrun: second word dropped while first is unacknowledged
        send_word(4'hA, 0, 1'b0, 4'hA);
        send_word(4'h5, 0, 1'b0, 4'hA);
        check("ovr_dout", dout, 4'hA);
        check("ovr_flag", ovr, 1);
        check("ovr_dvalid", dvalid, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("ovr_sticky", ovr, 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("ovr_clear", ovr, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_ack", dvalid, 0);

        // Ack coinciding with completion loads the new word
        send_word(4'h9, 0, 1'b0, 4'h9);
        send_word(4'h3, 0, 1'b1, 4'h3);
        check("race_dout", dout, 4'h3);
        check("race_dvalid", dvalid, 1);
        check("race_ovr", ovr, 0);

        // Asynchronous reset mid-frame
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        check("pre_reset_cnt", cnt, 2);
        #2;
        clr_n = 1'b0;
        #1;
        check("areset_busy", busy, 0);
        check("areset_cnt", cnt, 0);
        check("areset_dvalid", dvalid, 0);
        check("areset_dout", dout, 0);
        #3;
        clr_n = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
